// File: rtl/sha256_round_ctrl.sv
// rtl/sha256_round_ctrl.sv - iterative SHA-256 compression controller, one round per clock
module sha256_usigma (
    input  logic [31:0] a,
    input  logic [31:0] e,
    output logic [31:0] sig0,
    output logic [31:0] sig1
);

    // Upper-case sigma functions: S0 on a (ror 2/13/22), S1 on e (ror 6/11/25)
    assign sig0 = {a[1:0], a[31:2]} ^ {a[12:0], a[31:13]} ^ {a[21:0], a[31:22]};
    assign sig1 = {e[5:0], e[31:6]} ^ {e[10:0], e[31:11]} ^ {e[24:0], e[31:25]};

endmodule

module sha256_round_ctrl #(
    parameter int ROUNDS = 64
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         start,
    input  logic         init,
    input  logic [511:0] block_in,
    output logic [5:0]   k_idx,
    input  logic [31:0]  k_word,
    output logic         busy,
    output logic         done,
    output logic [255:0] digest
);

    localparam logic [255:0] IV = 256'h6a09e667_bb67ae85_3c6ef372_a54ff53a_510e527f_9b05688c_1f83d9ab_5be0cd19;
    localparam logic [5:0]   LAST_ROUND = 6'(ROUNDS - 1);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_LOAD  = 2'd1,
        ST_ROUND = 2'd2,
        ST_FINAL = 2'd3
    } state_t;

    state_t      state;
    logic [5:0]  cnt;
    logic        init_q;
    logic [31:0] w     [16];
    logic [31:0] v     [8];
    logic [31:0] h_st  [8];

    logic [31:0] big_s0;
    logic [31:0] big_s1;
    logic [31:0] ch;
    logic [31:0] maj;
    logic [31:0] t1;
    logic [31:0] t2;
    logic [31:0] w_next;

    function automatic logic [31:0] iv_word(input int i);
        return IV[32*(7-i) +: 32];
    endfunction

    function automatic logic [31:0] lsig0(input logic [31:0] x);
        return {x[6:0], x[31:7]} ^ {x[17:0], x[31:18]} ^ {3'b000, x[31:3]};
    endfunction

    function automatic logic [31:0] lsig1(input logic [31:0] x);
        return {x[16:0], x[31:17]} ^ {x[18:0], x[31:19]} ^ {10'b0, x[31:10]};
    endfunction

    // Single shared sigma pair; v[0] is working var a, v[4] is e
    sha256_usigma u_usigma (
        .a    (v[0]),
        .e    (v[4]),
        .sig0 (big_s0),
        .sig1 (big_s1)
    );

    // Round datapath: compression temporaries and next schedule word
    always_comb begin
        ch     = (v[4] & v[5]) ^ (~v[4] & v[6]);
        maj    = (v[0] & v[1]) ^ (v[0] & v[2]) ^ (v[1] & v[2]);
        t1     = v[7] + big_s1 + ch + k_word + w[0];
        t2     = big_s0 + maj;
        w_next = lsig1(w[14]) + w[9] + lsig0(w[1]) + w[0];
    end

    // K ROM address follows the round counter only while rounds run
    assign k_idx  = (state == ST_ROUND) ? cnt : 6'd0;

    assign digest = {h_st[0], h_st[1], h_st[2], h_st[3], h_st[4], h_st[5], h_st[6], h_st[7]};

    // Control FSM with schedule, working and chaining registers
    always_ff @(posedge clk) begin
        if (rst) begin
            state  <= ST_IDLE;
            busy   <= 1'b0;
            done   <= 1'b0;
            cnt    <= 6'd0;
            init_q <= 1'b0;
            for (int i = 0; i < 8; i++) begin
                h_st[i] <= iv_word(i);
                v[i]    <= 32'd0;
            end
            for (int i = 0; i < 16; i++) begin
                w[i] <= 32'd0;
            end
        end else begin
            done <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (start) begin
                        for (int i = 0; i < 16; i++) begin
                            w[i] <= block_in[32*(15-i) +: 32];
                        end
                        init_q <= init;
                        busy   <= 1'b1;
                        state  <= ST_LOAD;
                    end
                end
                ST_LOAD: begin
                    // init restarts the chain, so H is rewritten to IV alongside a..h
                    for (int i = 0; i < 8; i++) begin
                        v[i] <= init_q ? iv_word(i) : h_st[i];
                        if (init_q) begin
                            h_st[i] <= iv_word(i);
                        end
                    end
                    cnt   <= 6'd0;
                    state <= ST_ROUND;
                end
                ST_ROUND: begin
                    v[0] <= t1 + t2;
                    v[1] <= v[0];
                    v[2] <= v[1];
                    v[3] <= v[2];
                    v[4] <= v[3] + t1;
                    v[5] <= v[4];
                    v[6] <= v[5];
                    v[7] <= v[6];
                    for (int i = 0; i < 15; i++) begin
                        w[i] <= w[i+1];
                    end
                    w[15] <= w_next;
                    if (cnt == LAST_ROUND) begin
                        state <= ST_FINAL;
                    end else begin
                        cnt <= cnt + 6'd1;
                    end
                end
                ST_FINAL: begin
                    for (int i = 0; i < 8; i++) begin
                        h_st[i] <= h_st[i] + v[i];
                    end
                    cnt   <= 6'd0;
                    done  <= 1'b1;
                    busy  <= 1'b0;
                    state <= ST_IDLE;
                end
                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_sha256_round_ctrl.sv
// tb/tb_sha256_round_ctrl.sv - directed self-checking bench for sha256_round_ctrl
module tb_sha256_round_ctrl;

    logic         clk = 1'b0;
    logic         rst;
    logic         start;
    logic         init;
    logic [511:0] block_in;
    logic [5:0]   k_idx;
    logic [31:0]  k_word;
    logic         busy;
    logic         done;
    logic [255:0] digest;

    int checks = 0;
    int errors = 0;

    localparam logic [31:0] K [64] = '{
        32'h428a2f98, 32'h71374491, 32'hb5c0fbcf, 32'he9b5dba5, 32'h3956c25b, 32'h59f111f1, 32'h923f82a4, 32'hab1c5ed5,
        32'hd807aa98, 32'h12835b01, 32'h243185be, 32'h550c7dc3, 32'h72be5d74, 32'h80deb1fe, 32'h9bdc06a7, 32'hc19bf174,
        32'he49b69c1, 32'hefbe4786, 32'h0fc19dc6, 32'h240ca1cc, 32'h2de92c6f, 32'h4a7484aa, 32'h5cb0a9dc, 32'h76f988da,
        32'h983e5152, 32'ha831c66d, 32'hb00327c8, 32'hbf597fc7, 32'hc6e00bf3, 32'hd5a79147, 32'h06ca6351, 32'h14292967,
        32'h27b70a85, 32'h2e1b2138, 32'h4d2c6dfc, 32'h53380d13, 32'h650a7354, 32'h766a0abb, 32'h81c2c92e, 32'h92722c85,
        32'ha2bfe8a1, 32'ha81a664b, 32'hc24b8b70, 32'hc76c51a3, 32'hd192e819, 32'hd6990624, 32'hf40e3585, 32'h106aa070,
        32'h19a4c116, 32'h1e376c08, 32'h2748774c, 32'h34b0bcb5, 32'h391c0cb3, 32'h4ed8aa4a, 32'h5b9cca4f, 32'h682e6ff3,
        32'h748f82ee, 32'h78a5636f, 32'h84c87814, 32'h8cc70208, 32'h90befffa, 32'ha4506ceb, 32'hbef9a3f7, 32'hc67178f2
    };

    localparam logic [255:0] IV        = 256'h6a09e667bb67ae853c6ef372a54ff53a510e527f9b05688c1f83d9ab5be0cd19;
    localparam logic [255:0] ABC_DIG   = 256'hba7816bf8f01cfea414140de5dae2223b00361a396177a9cb410ff61f20015ad;
    localparam logic [255:0] EMPTY_DIG = 256'he3b0c44298fc1c149afbf4c8996fb92427ae41e4649b934ca495991b7852b855;
    localparam logic [255:0] TWO_DIG   = 256'h248d6a61d20638b8e5c026930c3e6039a33ce45964ff2167f6ecedd419db06c1;

    localparam logic [511:0] ABC_BLK   = {32'h61626380, 448'h0, 32'h00000018};
    localparam logic [511:0] EMPTY_BLK = {32'h80000000, 480'h0};
    localparam logic [511:0] TWO_BLK1  = {32'h61626364, 32'h62636465, 32'h63646566, 32'h64656667,
                                          32'h65666768, 32'h66676869, 32'h6768696a, 32'h68696a6b,
                                          32'h696a6b6c, 32'h6a6b6c6d, 32'h6b6c6d6e, 32'h6c6d6e6f,
                                          32'h6d6e6f70, 32'h6e6f7071, 32'h80000000, 32'h00000000};
    localparam logic [511:0] TWO_BLK2  = {448'h0, 64'h00000000_000001c0};

    assign k_word = K[k_idx];

    always #5 clk = ~clk;

    sha256_round_ctrl #(.ROUNDS(64)) dut (
        .clk      (clk),
        .rst      (rst),
        .start    (start),
        .init     (init),
        .block_in (block_in),
        .k_idx    (k_idx),
        .k_word   (k_word),
        .busy     (busy),
        .done     (done),
        .digest   (digest)
    );

    task automatic check(input string tag, input logic [255:0] obs, input logic [255:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Called at a negedge. Launches one block, follows it to its done pulse and
    // returns at the negedge of the done cycle. edges counts the start edge too.
    task automatic run_block(input logic [511:0] blk, input logic ini, input int pulse_at,
                             output int edges, output int kerr);
        int exp_k;
        start    = 1'b1;
        block_in = blk;
        init     = ini;
        edges    = -1;
        kerr     = 0;
        for (int j = 0; j < 100; j++) begin
            @(negedge clk);
            if (j == 0) begin
                block_in = {16{$urandom()}};
                init     = ~ini;
            end
            start = (pulse_at >= 0) && (j == pulse_at + 1);
            if (start) begin
                block_in = EMPTY_BLK;
                init     = 1'b1;
            end
            if (done === 1'b1) begin
                edges = j + 1;
                break;
            end
            exp_k = (j >= 1 && j <= 64) ? j - 1 : 0;
            if (k_idx !== 6'(exp_k) || busy !== 1'b1) kerr++;
        end
        start = 1'b0;
    endtask

    int e1;
    int e2;
    int k1;
    int k2;
    int cnt_done;
    int cnt_busy;
    bit found;

    initial begin
        rst      = 1'b1;
        start    = 1'b0;
        init     = 1'b0;
        block_in = '0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("reset_busy",   256'(busy),  256'd0);
        check("reset_done",   256'(done),  256'd0);
        check("reset_kidx",   256'(k_idx), 256'd0);
        check("reset_digest", digest,      IV);
        rst = 1'b0;
        @(negedge clk);

        // "abc" from IV
        run_block(ABC_BLK, 1'b1, -1, e1, k1);
        check("abc_latency", 256'(e1), 256'd67);
        check("abc_kidx_seq", 256'(k1), 256'd0);
        check("abc_digest", digest, ABC_DIG);
        @(negedge clk);
        check("abc_done_one_cycle", 256'(done), 256'd0);
        check("abc_digest_hold", digest, ABC_DIG);

        // empty message
        run_block(EMPTY_BLK, 1'b1, -1, e1, k1);
        check("empty_latency", 256'(e1), 256'd67);
        check("empty_digest", digest, EMPTY_DIG);
        @(negedge clk);

        // two-block message, second start in the done cycle of the first
        run_block(TWO_BLK1, 1'b1, -1, e1, k1);
        run_block(TWO_BLK2, 1'b0, -1, e2, k2);
        check("two_total_clocks", 256'(e1 + e2), 256'd134);
        check("two_kidx_seq", 256'(k1 + k2), 256'd0);
        check("two_digest", digest, TWO_DIG);
        @(negedge clk);

        // start pulse during round 10 is ignored
        run_block(ABC_BLK, 1'b1, 10, e1, k1);
        check("pulse_latency", 256'(e1), 256'd67);
        check("pulse_kidx_seq", 256'(k1), 256'd0);
        check("pulse_digest", digest, ABC_DIG);
        cnt_done = 0;
        for (int j = 0; j < 70; j++) begin
            @(negedge clk);
            if (done === 1'b1) cnt_done++;
        end
        check("pulse_no_extra_done", 256'(cnt_done), 256'd0);

        // reset at round 30 of a block chained from the "abc" digest
        start    = 1'b1;
        block_in = EMPTY_BLK;
        init     = 1'b0;
        @(negedge clk);
        start = 1'b0;
        found = 1'b0;
        for (int j = 0; j < 100; j++) begin
            @(negedge clk);
            if (k_idx === 6'd30) begin
                found = 1'b1;
                break;
            end
        end
        check("rst30_reached", 256'(found), 256'd1);
        check("rst30_digest_before", digest, ABC_DIG);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check("rst30_busy",   256'(busy),  256'd0);
        check("rst30_done",   256'(done),  256'd0);
        check("rst30_kidx",   256'(k_idx), 256'd0);
        check("rst30_digest", digest,      IV);

        // init = 0 straight after reset chains from IV
        run_block(ABC_BLK, 1'b0, -1, e1, k1);
        check("post_rst_latency", 256'(e1), 256'd67);
        check("post_rst_digest", digest, ABC_DIG);
        @(negedge clk);

        // reset wins over a simultaneous start
        rst      = 1'b1;
        start    = 1'b1;
        block_in = ABC_BLK;
        init     = 1'b1;
        @(negedge clk);
        rst   = 1'b0;
        start = 1'b0;
        check("rst_start_busy",   256'(busy), 256'd0);
        check("rst_start_digest", digest,     IV);
        cnt_done = 0;
        cnt_busy = 0;
        for (int j = 0; j < 70; j++) begin
            @(negedge clk);
            if (done === 1'b1) cnt_done++;
            if (busy !== 1'b0) cnt_busy++;
        end
        check("rst_start_no_done", 256'(cnt_done), 256'd0);
        check("rst_start_stay_idle", 256'(cnt_busy), 256'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
